// File: rtl/pe_mac_dbw.sv
// Weight-stationary systolic PE with sign-magnitude operands.
// Runs as one full-width lane or as two packed half-width lanes, chosen per operation.
// Weights are double-buffered: shadow <- w_in, active <- shadow.
// The accumulator saturates or wraps, and a sticky overflow flag records any overflow.
// Handshake: x_valid_in qualifies x_in/x_sign_in/sum_in/width_in/acc_clr in the same cycle.
// sum_valid rises exactly two edges later. There is no back-pressure, so every valid operand is consumed.
module pe_mac_dbw #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              _res,
    input  logic              width_in,
    input  logic              x_valid_in,
    input  logic [DATA_W-1:0] x_in,
    input  logic [1:0]        x_sign_in,
    input  logic [ACC_W-1:0]  sum_in,
    input  logic              acc_clr,
    input  logic [DATA_W-1:0] w_in,
    input  logic [1:0]        w_sign_in,
    input  logic              w_load,
    input  logic              w_swap,
    input  logic              ovf_clr,
    output logic              width_out,
    output logic              x_valid_out,
    output logic [DATA_W-1:0] x_out,
    output logic [1:0]        x_sign_out,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    output logic              ovf
);
    localparam int HD = DATA_W / 2;   // half-lane operand width
    localparam int HA = ACC_W / 2;    // half-lane accumulator width
    localparam int PW = 2 * DATA_W;   // full-lane product width
    localparam int FW = ACC_W + 2;    // full-lane exact-sum width
    localparam int HW = HA + 2;       // half-lane exact-sum width

    // Weight buffers
    logic [DATA_W-1:0] w_sh_q, w_sh_d, w_act_q, w_act_d;
    logic [1:0]        w_sh_sign_q, w_sh_sign_d, w_act_sign_q, w_act_sign_d;

    // Pass-through registers
    logic              width_q, x_valid_q;
    logic [DATA_W-1:0] x_q;
    logic [1:0]        x_sign_q;

    // Stage 1 registers
    logic              s1_valid_q, s1_width_q;
    logic [PW-1:0]     s1_pfull_q, pfull_d;
    logic [DATA_W-1:0] s1_phi_q, phi_d, s1_plo_q, plo_d;
    logic [1:0]        s1_neg_q, neg_d;
    logic [ACC_W-1:0]  s1_sum_q, s1_sum_d;

    // Stage 2 registers
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic              sum_valid_q, ovf_q, ovf_d;

    // Stage 2 working values
    logic [FW-1:0]     f_mag, f_prod, f_wide;
    logic [HW-1:0]     h_mag, h_prod, h_wide, l_mag, l_prod, l_wide;
    logic [ACC_W-1:0]  f_res;
    logic [HA-1:0]     h_res, l_res;
    logic              f_ovf, h_ovf, l_ovf, lane_ovf;

    // Weight next-state: a swap copies the shadow value as it was before this edge
    always_comb begin
        w_sh_d       = w_load ? w_in      : w_sh_q;
        w_sh_sign_d  = w_load ? w_sign_in : w_sh_sign_q;
        w_act_d      = w_swap ? w_sh_q      : w_act_q;
        w_act_sign_d = w_swap ? w_sh_sign_q : w_act_sign_q;
    end

    // Stage 1 datapath: full and half-lane magnitude products against the active weight
    always_comb begin
        pfull_d  = {{DATA_W{1'b0}}, x_in} * {{DATA_W{1'b0}}, w_act_q};
        phi_d    = {{HD{1'b0}}, x_in[DATA_W-1:HD]} * {{HD{1'b0}}, w_act_q[DATA_W-1:HD]};
        plo_d    = {{HD{1'b0}}, x_in[HD-1:0]} * {{HD{1'b0}}, w_act_q[HD-1:0]};
        neg_d    = x_sign_in ^ w_act_sign_q;
        s1_sum_d = acc_clr ? '0 : sum_in;
    end

    // Stage 2 datapath: exact signed add per lane, then overflow detection and clamp or wrap
    always_comb begin
        f_mag  = {{(FW-PW){1'b0}}, s1_pfull_q};
        f_prod = s1_neg_q[1] ? -f_mag : f_mag;
        f_wide = {{2{s1_sum_q[ACC_W-1]}}, s1_sum_q} + f_prod;
        f_ovf  = (f_wide[FW-1] != f_wide[FW-2]) || (f_wide[FW-2] != f_wide[FW-3]);
        f_res  = f_wide[ACC_W-1:0];
        if (f_ovf && (SAT != 0))
            f_res = f_wide[FW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

        h_mag  = {{(HW-DATA_W){1'b0}}, s1_phi_q};
        h_prod = s1_neg_q[1] ? -h_mag : h_mag;
        h_wide = {{2{s1_sum_q[ACC_W-1]}}, s1_sum_q[ACC_W-1:HA]} + h_prod;
        h_ovf  = (h_wide[HW-1] != h_wide[HW-2]) || (h_wide[HW-2] != h_wide[HW-3]);
        h_res  = h_wide[HA-1:0];
        if (h_ovf && (SAT != 0))
            h_res = h_wide[HW-1] ? {1'b1, {(HA-1){1'b0}}} : {1'b0, {(HA-1){1'b1}}};

        l_mag  = {{(HW-DATA_W){1'b0}}, s1_plo_q};
        l_prod = s1_neg_q[0] ? -l_mag : l_mag;
        l_wide = {{2{s1_sum_q[HA-1]}}, s1_sum_q[HA-1:0]} + l_prod;
        l_ovf  = (l_wide[HW-1] != l_wide[HW-2]) || (l_wide[HW-2] != l_wide[HW-3]);
        l_res  = l_wide[HA-1:0];
        if (l_ovf && (SAT != 0))
            l_res = l_wide[HW-1] ? {1'b1, {(HA-1){1'b0}}} : {1'b0, {(HA-1){1'b1}}};
    end

    // Stage 2 next-state: the result holds when no operand is in flight; a new overflow outranks ovf_clr
    always_comb begin
        sum_d    = sum_q;
        lane_ovf = 1'b0;
        if (s1_valid_q) begin
            if (s1_width_q) begin
                sum_d    = f_res;
                lane_ovf = f_ovf;
            end else begin
                sum_d    = {h_res, l_res};
                lane_ovf = h_ovf || l_ovf;
            end
        end
        ovf_d = (ovf_q && !ovf_clr) || lane_ovf;
    end

    // Weight buffer registers
    always_ff @(posedge clk or posedge _res) begin
        if (_res) begin
            w_sh_q       <= '0;
            w_sh_sign_q  <= '0;
            w_act_q      <= '0;
            w_act_sign_q <= '0;
        end else begin
            w_sh_q       <= w_sh_d;
            w_sh_sign_q  <= w_sh_sign_d;
            w_act_q      <= w_act_d;
            w_act_sign_q <= w_act_sign_d;
        end
    end

    // Systolic pass-through: forwarded every edge whether or not the operand is valid
    always_ff @(posedge clk or posedge _res) begin
        if (_res) begin
            width_q   <= 1'b0;
            x_valid_q <= 1'b0;
            x_q       <= '0;
            x_sign_q  <= '0;
        end else begin
            width_q   <= width_in;
            x_valid_q <= x_valid_in;
            x_q       <= x_in;
            x_sign_q  <= x_sign_in;
        end
    end

    // Stage 1 register: capture products, signs, mode and partial sum of a valid operand
    always_ff @(posedge clk or posedge _res) begin
        if (_res) begin
            s1_valid_q <= 1'b0;
            s1_width_q <= 1'b0;
            s1_pfull_q <= '0;
            s1_phi_q   <= '0;
            s1_plo_q   <= '0;
            s1_neg_q   <= '0;
            s1_sum_q   <= '0;
        end else begin
            s1_valid_q <= x_valid_in;
            if (x_valid_in) begin
                s1_width_q <= width_in;
                s1_pfull_q <= pfull_d;
                s1_phi_q   <= phi_d;
                s1_plo_q   <= plo_d;
                s1_neg_q   <= neg_d;
                s1_sum_q   <= s1_sum_d;
            end
        end
    end

    // Stage 2 register: accumulated result, its valid strobe and the sticky overflow flag
    always_ff @(posedge clk or posedge _res) begin
        if (_res) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            sum_valid_q <= s1_valid_q;
            ovf_q       <= ovf_d;
        end
    end

    assign width_out   = width_q;
    assign x_valid_out = x_valid_q;
    assign x_out       = x_q;
    assign x_sign_out  = x_sign_q;
    assign sum_out     = sum_q;
    assign sum_valid   = sum_valid_q;
    assign ovf         = ovf_q;
endmodule

// File: tb/tb_pe_mac_dbw.sv
// Bench for pe_mac_dbw.
// One instance saturates and one wraps; both are driven by the same stimulus.
// Every operation pushes its expected result into a queue, and a monitor pops one entry per sum_valid.
module tb_pe_mac_dbw;
    logic        clk, rst;
    logic        width_in, x_valid_in, acc_clr, w_load, w_swap, ovf_clr;
    logic [15:0] x_in, w_in;
    logic [1:0]  x_sign_in, w_sign_in;
    logic [31:0] sum_in;

    logic        s_width_out, s_x_valid_out, s_sum_valid, s_ovf;
    logic [15:0] s_x_out;
    logic [1:0]  s_x_sign_out;
    logic [31:0] s_sum_out;
    logic        w_width_out, w_x_valid_out, w_sum_valid, w_ovf;
    logic [15:0] w_x_out;
    logic [1:0]  w_x_sign_out;
    logic [31:0] w_sum_out;

    logic [31:0] exp_sat_q[$];
    logic [31:0] exp_wrap_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    pe_mac_dbw #(.DATA_W(16), .ACC_W(32), .SAT(1)) dut_sat (
        .clk(clk), ._res(rst), .width_in(width_in), .x_valid_in(x_valid_in),
        .x_in(x_in), .x_sign_in(x_sign_in), .sum_in(sum_in), .acc_clr(acc_clr),
        .w_in(w_in), .w_sign_in(w_sign_in), .w_load(w_load), .w_swap(w_swap),
        .ovf_clr(ovf_clr), .width_out(s_width_out), .x_valid_out(s_x_valid_out),
        .x_out(s_x_out), .x_sign_out(s_x_sign_out), .sum_out(s_sum_out),
        .sum_valid(s_sum_valid), .ovf(s_ovf)
    );

    pe_mac_dbw #(.DATA_W(16), .ACC_W(32), .SAT(0)) dut_wrap (
        .clk(clk), ._res(rst), .width_in(width_in), .x_valid_in(x_valid_in),
        .x_in(x_in), .x_sign_in(x_sign_in), .sum_in(sum_in), .acc_clr(acc_clr),
        .w_in(w_in), .w_sign_in(w_sign_in), .w_load(w_load), .w_swap(w_swap),
        .ovf_clr(ovf_clr), .width_out(w_width_out), .x_valid_out(w_x_valid_out),
        .x_out(w_x_out), .x_sign_out(w_x_sign_out), .sum_out(w_sum_out),
        .sum_valid(w_sum_valid), .ovf(w_ovf)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Driver tasks
    task automatic load_swap(input logic [15:0] w, input logic [1:0] ws);
        w_in = w; w_sign_in = ws; w_load = 1'b1;
        step();
        w_load = 1'b0; w_swap = 1'b1;
        step();
        w_swap = 1'b0;
    endtask

    task automatic op(input logic wd, input logic [15:0] x, input logic [1:0] xs,
                      input logic [31:0] s, input logic clr,
                      input logic [31:0] e_sat, input logic [31:0] e_wrap);
        width_in = wd; x_in = x; x_sign_in = xs; sum_in = s; acc_clr = clr;
        x_valid_in = 1'b1;
        exp_sat_q.push_back(e_sat);
        exp_wrap_q.push_back(e_wrap);
        step();
        x_valid_in = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
    endtask

    // Scoreboard monitor: each presented result retires the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (s_sum_valid) begin
                if (exp_sat_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sum_sat: unexpected result %h, nothing expected", s_sum_out);
                end else begin
                    chk("sum_sat", s_sum_out, exp_sat_q.pop_front());
                end
            end
            if (w_sum_valid) begin
                if (exp_wrap_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sum_wrap: unexpected result %h, nothing expected", w_sum_out);
                end else begin
                    chk("sum_wrap", w_sum_out, exp_wrap_q.pop_front());
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        n_cmp++; n_bad++;
        $display("FAIL timeout: bench did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Directed stimulus
    initial begin
        int t5_exp[8];
        t5_exp = '{1, 2, 3, 4, 10, 12, 14, 16};
        rst = 1'b1;
        width_in = 1'b0; x_valid_in = 1'b0; acc_clr = 1'b0; w_load = 1'b0;
        w_swap = 1'b0; ovf_clr = 1'b0; x_in = '0; w_in = '0;
        x_sign_in = '0; w_sign_in = '0; sum_in = '0;
        #2;
        chk("rst_sum_out", s_sum_out, 32'h0);
        chk("rst_sum_valid", s_sum_valid, 1'b0);
        chk("rst_ovf", s_ovf, 1'b0);
        chk("rst_x_valid_out", s_x_valid_out, 1'b0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Full lane: 100000 + 300 * (-200) = 40000, visible two edges after the operand
        load_swap(16'd300, 2'b00);
        op(1'b1, 16'd200, 2'b10, 32'd100000, 1'b0, 32'd40000, 32'd40000);
        chk("pass_x_out", s_x_out, 32'd200);
        chk("pass_x_sign_out", s_x_sign_out, 2'b10);
        chk("pass_width_out", s_width_out, 1'b1);
        chk("pass_x_valid_out", s_x_valid_out, 1'b1);
        chk("lat_not_yet", s_sum_valid, 1'b0);
        step();
        chk("lat_valid", s_sum_valid, 1'b1);
        chk("lat_sum", s_sum_out, 32'd40000);
        chk("pass_x_valid_drop", s_x_valid_out, 1'b0);
        // acc_clr ignores sum_in: 0 - 60000
        op(1'b1, 16'd200, 2'b10, 32'd12345, 1'b1, 32'hFFFF15A0, 32'hFFFF15A0);
        idle(3);
        chk("hold_sum", s_sum_out, 32'hFFFF15A0);
        chk("hold_valid", s_sum_valid, 1'b0);

        // Packed lanes: hi 7 + 3*10 = 0x25, lo 0 - 5*20 = 0xFF9C
        load_swap(16'h0305, 2'b01);
        op(1'b0, 16'h0A14, 2'b00, 32'h00070000, 1'b0, 32'h0025FF9C, 32'h0025FF9C);
        // Both lanes negative: no borrow crosses from lo into hi
        op(1'b0, 16'h0402, 2'b10, 32'h00050003, 1'b0, 32'hFFF9FFF9, 32'hFFF9FFF9);
        // Back-to-back mode change: full 0x0305 * 2 = 1546
        op(1'b1, 16'd2, 2'b00, 32'h0, 1'b0, 32'h0000060A, 32'h0000060A);
        op(1'b0, 16'h0A14, 2'b00, 32'h00070000, 1'b0, 32'h0025FF9C, 32'h0025FF9C);
        idle(3);
        chk("packed_no_ovf", s_ovf, 1'b0);

        // Full-lane positive overflow and sticky flag
        load_swap(16'hFFFF, 2'b00);
        op(1'b1, 16'hFFFF, 2'b00, 32'h0, 1'b0, 32'h7FFFFFFF, 32'hFFFE0001);
        idle(1);
        chk("ovf_set_sat", s_ovf, 1'b1);
        chk("ovf_set_wrap", w_ovf, 1'b1);
        op(1'b1, 16'd1, 2'b00, 32'h0, 1'b0, 32'h0000FFFF, 32'h0000FFFF);
        idle(3);
        chk("ovf_sticky", s_ovf, 1'b1);
        clear_ovf();
        chk("ovf_cleared_sat", s_ovf, 1'b0);
        chk("ovf_cleared_wrap", w_ovf, 1'b0);
        // Negative overflow arriving on the same edge as ovf_clr
        op(1'b1, 16'hFFFF, 2'b10, 32'h80000000, 1'b0, 32'h80000000, 32'h8001FFFF);
        clear_ovf();
        chk("ovf_beats_clr_sat", s_ovf, 1'b1);
        chk("ovf_beats_clr_wrap", w_ovf, 1'b1);
        idle(1);
        clear_ovf();

        // Packed overflow in the lo lane only: 0x7FFF + 255*255
        load_swap(16'h01FF, 2'b00);
        op(1'b0, 16'h01FF, 2'b00, 32'h00017FFF, 1'b0, 32'h00027FFF, 32'h00027E00);
        idle(1);
        chk("packed_ovf", s_ovf, 1'b1);
        clear_ovf();
        chk("packed_ovf_clr", s_ovf, 1'b0);

        // Double-buffered weights in an unbroken stream. The swap rides with x=4,
        // which still sees the old weight, so x=5 is the first to use W=2.
        load_swap(16'd1, 2'b00);
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin w_in = 16'd2; w_load = 1'b1; end
            if (i == 4) begin w_in = 16'd3; w_load = 1'b1; w_swap = 1'b1; end
            op(1'b1, 16'(i), 2'b00, 32'h0, 1'b0, 32'(t5_exp[i-1]), 32'(t5_exp[i-1]));
            w_load = 1'b0; w_swap = 1'b0;
        end
        idle(2);
        w_swap = 1'b1;
        step();
        w_swap = 1'b0;
        op(1'b1, 16'd5, 2'b00, 32'h0, 1'b0, 32'd15, 32'd15);
        idle(2);

        // Asynchronous reset in mid-stream
        op(1'b1, 16'd1, 2'b00, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 32'h80000002);
        idle(2);
        chk("pre_rst_ovf", s_ovf, 1'b1);
        width_in = 1'b1; x_in = 16'd7; x_sign_in = 2'b11; sum_in = 32'h0; x_valid_in = 1'b1;
        step();
        x_valid_in = 1'b0; x_in = '0; x_sign_in = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sum_out", s_sum_out, 32'h0);
        chk("arst_sum_out_wrap", w_sum_out, 32'h0);
        chk("arst_ovf", s_ovf, 1'b0);
        chk("arst_x_out", s_x_out, 32'h0);
        chk("arst_x_sign_out", s_x_sign_out, 2'b00);
        chk("arst_width_out", s_width_out, 1'b0);
        chk("arst_x_valid_out", s_x_valid_out, 1'b0);
        chk("arst_sum_valid", s_sum_valid, 1'b0);
        idle(2);
        rst = 1'b0;
        idle(1);
        // Active weight cleared: sum_in passes through unchanged
        op(1'b1, 16'd9, 2'b00, 32'd12345, 1'b0, 32'd12345, 32'd12345);
        idle(2);
        // Shadow cleared too
        w_swap = 1'b1;
        step();
        w_swap = 1'b0;
        op(1'b1, 16'd9, 2'b00, 32'd5, 1'b0, 32'd5, 32'd5);
        idle(3);

        chk("exp_sat_drained", exp_sat_q.size(), 32'd0);
        chk("exp_wrap_drained", exp_wrap_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
